operand_fetch: RTL and testbench

- Register-read stage between decode and execute in the 32-bit ARM pipeline.
- Accepts decoded instructions carrying source register numbers (Rn, Rm) and drives the register file read addresses.
- The register file returns read data one cycle after the address is sampled. This block absorbs that latency and bypasses same-edge writebacks, which the register file would otherwise return as stale data.
- Substitutes PC+8 for r15 and presents both operands to execute over a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/operand_fetch_if.sv | 46 ++++
 rtl/operand_fetch_bypass.sv | 56 +++++
 rtl/operand_fetch.sv | 99 +++++++++
 tb/tb_operand_fetch.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-number and word types for the pipeline
// Purpose: common widths, the PC register number and the default r15 read offset.
package cpu_pkg;

    localparam int REG_W  = 4;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  reg_num_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam reg_num_t REG_PC        = 4'd15;
    localparam word_t    DEF_PC_OFFSET = 32'd8;

    // r15 reads return the instruction address plus the pipeline offset, wrapping at 2^32.
    function automatic word_t pc_operand(input word_t pc, input word_t offset);
        return pc + offset;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode/regfile/writeback/execute bus of the operand fetch stage
// Purpose: bundles every non-clock signal of operand_fetch.
//   slave  : the operand fetch stage itself
//   master : the surrounding pipeline (decode, register file, writeback, execute)
interface operand_fetch_if
    import cpu_pkg::*;
#(
    parameter int PAYLOAD_W = 64
) ();

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    reg_num_t             in_rn;
    reg_num_t             in_rm;
    word_t                in_pc;
    logic [PAYLOAD_W-1:0] in_payload;
    reg_num_t             rf_read_regA;
    reg_num_t             rf_read_regB;
    word_t                rf_read_dataA;
    word_t                rf_read_dataB;
    logic                 wb_en;
    reg_num_t             wb_reg;
    word_t                wb_data;
    logic                 out_valid;
    logic                 out_ready;
    word_t                out_opA;
    word_t                out_opB;
    word_t                out_pc;
    logic [PAYLOAD_W-1:0] out_payload;

    modport slave (
        input  flush, in_valid, in_rn, in_rm, in_pc, in_payload,
        input  rf_read_dataA, rf_read_dataB, wb_en, wb_reg, wb_data, out_ready,
        output in_ready, rf_read_regA, rf_read_regB,
        output out_valid, out_opA, out_opB, out_pc, out_payload
    );

    modport master (
        output flush, in_valid, in_rn, in_rm, in_pc, in_payload,
        output rf_read_dataA, rf_read_dataB, wb_en, wb_reg, wb_data, out_ready,
        input  in_ready, rf_read_regA, rf_read_regB,
        input  out_valid, out_opA, out_opB, out_pc, out_payload
    );

endinterface

// File: rtl/operand_fetch_bypass.sv
// rtl/operand_fetch_bypass.sv - per-port writeback bypass capture and operand select
// Purpose: one source operand. Remembers whether the writeback on the edge that
// sampled the read address targeted that address, then picks PC+offset, the
// bypassed value or the register file data.
// Ports: clk, reset; rd_addr (address sampled by the regfile this cycle),
//        src_reg (held source register), pc (held instruction address),
//        wb_en/wb_reg/wb_data, rf_data (regfile read data), operand (result).
module operand_bypass
    import cpu_pkg::*;
#(
    parameter word_t PC_OFFSET = DEF_PC_OFFSET
) (
    input  logic     clk,
    input  logic     reset,
    input  reg_num_t rd_addr,
    input  reg_num_t src_reg,
    input  word_t    pc,
    input  logic     wb_en,
    input  reg_num_t wb_reg,
    input  word_t    wb_data,
    input  word_t    rf_data,
    output word_t    operand
);

    logic  byp_hit_q, byp_hit_d;
    word_t byp_data_q, byp_data_d;

    // The regfile returns pre-write data when it is written on the same edge that
    // samples the read, so that write is captured here and substituted next cycle.
    always_comb begin
        byp_hit_d  = wb_en && (wb_reg == rd_addr);
        byp_data_d = wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
        end
    end

    // r15 is not a real register: it never bypasses.
    always_comb begin
        if (src_reg == REG_PC) begin
            operand = pc_operand(pc, PC_OFFSET);
        end else if (byp_hit_q) begin
            operand = byp_data_q;
        end else begin
            operand = rf_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage between decode and execute
// Purpose: accepts decoded instructions, drives register file read addresses,
// absorbs the one-cycle read latency and presents both operands to execute.
// Ports: clk, reset (async, active-high), bus (operand_fetch_if.slave: flush,
//        in_* from decode, rf_* to/from the register file, wb_* writeback,
//        out_* to execute).
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int    PAYLOAD_W = 64,
    parameter word_t PC_OFFSET = DEF_PC_OFFSET
) (
    input  logic            clk,
    input  logic            reset,
    operand_fetch_if.slave  bus
);

    logic                 s2_valid_q, s2_valid_d;
    reg_num_t             s2_rn_q, s2_rn_d;
    reg_num_t             s2_rm_q, s2_rm_d;
    word_t                s2_pc_q, s2_pc_d;
    logic [PAYLOAD_W-1:0] s2_payload_q, s2_payload_d;
    logic                 accept;
    logic                 hold;

    assign bus.in_ready = !reset && !bus.flush && (!s2_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign hold         = s2_valid_q && !bus.out_ready;

    // While stalled, keep re-reading the held sources so writes during the stall show up.
    assign bus.rf_read_regA = hold ? s2_rn_q : bus.in_rn;
    assign bus.rf_read_regB = hold ? s2_rm_q : bus.in_rm;

    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_rn_d      = s2_rn_q;
        s2_rm_d      = s2_rm_q;
        s2_pc_d      = s2_pc_q;
        s2_payload_d = s2_payload_q;
        if (bus.flush) begin
            s2_valid_d = 1'b0;
        end else if (accept) begin
            s2_valid_d   = 1'b1;
            s2_rn_d      = bus.in_rn;
            s2_rm_d      = bus.in_rm;
            s2_pc_d      = bus.in_pc;
            s2_payload_d = bus.in_payload;
        end else if (s2_valid_q && bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q   <= 1'b0;
            s2_rn_q      <= '0;
            s2_rm_q      <= '0;
            s2_pc_q      <= '0;
            s2_payload_q <= '0;
        end else begin
            s2_valid_q   <= s2_valid_d;
            s2_rn_q      <= s2_rn_d;
            s2_rm_q      <= s2_rm_d;
            s2_pc_q      <= s2_pc_d;
            s2_payload_q <= s2_payload_d;
        end
    end

    assign bus.out_valid   = s2_valid_q;
    assign bus.out_pc      = s2_pc_q;
    assign bus.out_payload = s2_payload_q;

    operand_bypass #(.PC_OFFSET(PC_OFFSET)) u_byp_a (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (bus.rf_read_regA),
        .src_reg (s2_rn_q),
        .pc      (s2_pc_q),
        .wb_en   (bus.wb_en),
        .wb_reg  (bus.wb_reg),
        .wb_data (bus.wb_data),
        .rf_data (bus.rf_read_dataA),
        .operand (bus.out_opA)
    );

    operand_bypass #(.PC_OFFSET(PC_OFFSET)) u_byp_b (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (bus.rf_read_regB),
        .src_reg (s2_rm_q),
        .pc      (s2_pc_q),
        .wb_en   (bus.wb_en),
        .wb_reg  (bus.wb_reg),
        .wb_data (bus.wb_data),
        .rf_data (bus.rf_read_dataB),
        .operand (bus.out_opB)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch
module tb_operand_fetch;
    import cpu_pkg::*;

    localparam int PW = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    operand_fetch_if #(.PAYLOAD_W(PW)) bus ();

    operand_fetch #(.PAYLOAD_W(PW), .PC_OFFSET(32'd8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Register file: synchronous write, read data registered from the sampled address
    // (a write on the sampling edge is returned as the old value).
    word_t rf [16];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            bus.rf_read_dataA <= '0;
            bus.rf_read_dataB <= '0;
        end else begin
            bus.rf_read_dataA <= rf[bus.rf_read_regA];
            bus.rf_read_dataB <= rf[bus.rf_read_regB];
            if (bus.wb_en) rf[bus.wb_reg] <= bus.wb_data;
        end
    end

    function automatic word_t arch_val(input reg_num_t r, input word_t pc);
        return (r == 4'd15) ? pc + 32'd8 : rf[r];
    endfunction

    typedef struct {
        reg_num_t       rn;
        reg_num_t       rm;
        word_t          pc;
        logic [PW-1:0]  payload;
    } exp_t;
    exp_t sb [$];

    // Scoreboard: push on accept, pop on transfer, drop on flush of a stalled entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow unexpected out_pc=%h required=no_output", bus.out_pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_payload", bus.out_payload, e.payload);
                    chk("sb_pc", bus.out_pc, e.pc);
                    chk("sb_opA", bus.out_opA, arch_val(e.rn, e.pc));
                    chk("sb_opB", bus.out_opB, arch_val(e.rm, e.pc));
                end
            end else if (bus.out_valid && bus.flush && sb.size() != 0) begin
                void'(sb.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                e.rn = bus.in_rn;
                e.rm = bus.in_rm;
                e.pc = bus.in_pc;
                e.payload = bus.in_payload;
                sb.push_back(e);
            end
        end
    end

    typedef struct {
        reg_num_t rn;
        reg_num_t rm;
        word_t    pc;
        logic     wb_en;
        reg_num_t wb_reg;
        word_t    wb_data;
        word_t    exp_a;
        word_t    exp_b;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        word_t v;
        vecs[0] = '{4'd3,  4'd4,  32'h0000_0100, 1'b1 & 1'b0, 4'd0,  32'h0,         32'h0000_0011, 32'h0000_0022};
        vecs[1] = '{4'd5,  4'd4,  32'h0000_0104, 1'b1, 4'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0022};
        vecs[2] = '{4'd15, 4'd15, 32'hFFFF_FFFC, 1'b1, 4'd15, 32'h1234_5678, 32'h0000_0004, 32'h0000_0004};
        vecs[3] = '{4'd6,  4'd6,  32'h0000_0200, 1'b1, 4'd6,  32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[4] = '{4'd0,  4'd9,  32'h0000_0300, 1'b1, 4'd9,  32'h0000_0099, 32'h1000_0000, 32'h0000_0099};
        vecs[5] = '{4'd2,  4'd15, 32'h0000_0400, 1'b0, 4'd2,  32'h0000_FFFF, 32'h1000_0002, 32'h0000_0408};
        vecs[6] = '{4'd15, 4'd1,  32'h0000_0010, 1'b1, 4'd1,  32'h0000_0ABC, 32'h0000_0018, 32'h0000_0ABC};

        bus.flush = 0; bus.in_valid = 0; bus.in_rn = 0; bus.in_rm = 0; bus.in_pc = 0;
        bus.in_payload = 0; bus.wb_en = 0; bus.wb_reg = 0; bus.wb_data = 0; bus.out_ready = 0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_payload", bus.out_payload, 64'h0);
        tick();
        reset = 0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        tick();

        for (int i = 0; i < 16; i++) begin
            case (i)
                3: v = 32'h0000_0011;
                4: v = 32'h0000_0022;
                5: v = 32'h0;
                15: v = 32'hBAD0_000F;
                default: v = 32'h1000_0000 + i;
            endcase
            bus.wb_en = 1; bus.wb_reg = 4'(i); bus.wb_data = v;
            tick();
        end
        bus.wb_en = 0;
        tick();

        for (int k = 0; k < 7; k++) begin
            bus.in_valid = 1; bus.in_rn = vecs[k].rn; bus.in_rm = vecs[k].rm;
            bus.in_pc = vecs[k].pc; bus.in_payload = {32'hA5A5_0000, 32'(k)};
            bus.out_ready = 1;
            bus.wb_en = vecs[k].wb_en; bus.wb_reg = vecs[k].wb_reg; bus.wb_data = vecs[k].wb_data;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", k), bus.in_ready, 1'b1);
            tick();
            bus.in_valid = 0; bus.wb_en = 0;
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", k), bus.out_valid, 1'b1);
            chk($sformatf("v%0d_opA", k), bus.out_opA, vecs[k].exp_a);
            chk($sformatf("v%0d_opB", k), bus.out_opB, vecs[k].exp_b);
            chk($sformatf("v%0d_pc", k), bus.out_pc, vecs[k].pc);
            chk($sformatf("v%0d_payload", k), bus.out_payload, {32'hA5A5_0000, 32'(k)});
            tick();
        end

        // Stall holding r7, write r7 mid-stall.
        bus.in_valid = 1; bus.in_rn = 7; bus.in_rm = 3; bus.in_pc = 32'h500;
        bus.in_payload = 64'h5151_5151_0000_0007; bus.out_ready = 1;
        tick();
        bus.in_rn = 1; bus.in_rm = 2; bus.in_pc = 32'h600; bus.in_payload = 64'h6161_0000_0000_0001;
        bus.out_ready = 0;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) begin
                bus.wb_en = 1; bus.wb_reg = 7; bus.wb_data = 32'h55;
            end
            @(negedge clk);
            chk($sformatf("stall%0d_in_ready", s), bus.in_ready, 1'b0);
            chk($sformatf("stall%0d_out_valid", s), bus.out_valid, 1'b1);
            chk($sformatf("stall%0d_rdA", s), bus.rf_read_regA, 4'd7);
            chk($sformatf("stall%0d_payload", s), bus.out_payload, 64'h5151_5151_0000_0007);
            chk($sformatf("stall%0d_pc", s), bus.out_pc, 32'h500);
            chk($sformatf("stall%0d_opA", s), bus.out_opA, (s == 2) ? 32'h55 : 32'h1000_0007);
            chk($sformatf("stall%0d_opB", s), bus.out_opB, 32'h11);
            tick();
            bus.wb_en = 0;
        end
        bus.out_ready = 1;
        @(negedge clk);
        chk("stall_release_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 0;
        @(negedge clk);
        chk("stall_next_valid", bus.out_valid, 1'b1);
        chk("stall_next_payload", bus.out_payload, 64'h6161_0000_0000_0001);
        tick();

        // Back-to-back stream of four.
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1; bus.in_rn = 4'(8 + k); bus.in_rm = 4'(k);
            bus.in_pc = 32'h700 + 32'(4 * k); bus.in_payload = 64'hB0 + 64'(k);
            @(negedge clk);
            chk($sformatf("b2b%0d_in_ready", k), bus.in_ready, 1'b1);
            if (k > 0) chk($sformatf("b2b%0d_out_valid", k), bus.out_valid, 1'b1);
            tick();
        end
        bus.in_valid = 0;
        @(negedge clk);
        chk("b2b_last_valid", bus.out_valid, 1'b1);
        chk("b2b_last_payload", bus.out_payload, 64'hB3);
        tick();
        @(negedge clk);
        chk("b2b_drained", bus.out_valid, 1'b0);

        // Flush while stalled with a new instruction offered.
        bus.in_valid = 1; bus.in_rn = 10; bus.in_rm = 11; bus.in_pc = 32'h800;
        bus.in_payload = 64'hF1; bus.out_ready = 1;
        tick();
        bus.in_rn = 12; bus.in_payload = 64'hF2; bus.in_pc = 32'h804; bus.out_ready = 0;
        @(negedge clk);
        chk("flush_pre_valid", bus.out_valid, 1'b1);
        tick();
        bus.flush = 1;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 1'b0);
        tick();
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid, 1'b0);
        tick();
        // Flush while idle and ready: still nothing enters.
        bus.flush = 1; bus.in_valid = 1;
        @(negedge clk);
        chk("flush_idle_in_ready", bus.in_ready, 1'b0);
        tick();
        bus.flush = 0; bus.in_valid = 0;
        @(negedge clk);
        chk("flush_idle_out_valid", bus.out_valid, 1'b0);
        tick();

        // Asynchronous reset mid-stall.
        bus.in_valid = 1; bus.in_rn = 13; bus.in_rm = 14; bus.in_pc = 32'h900;
        bus.in_payload = 64'hE0; bus.out_ready = 1;
        tick();
        bus.in_valid = 0; bus.out_ready = 0;
        @(negedge clk);
        chk("arst_pre_valid", bus.out_valid, 1'b1);
        @(posedge clk);
        #2 reset = 1;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_in_ready", bus.in_ready, 1'b0);
        chk("arst_out_pc", bus.out_pc, 32'h0);
        chk("arst_out_payload", bus.out_payload, 64'h0);
        tick();
        reset = 0;
        @(negedge clk);
        chk("arst_after_valid", bus.out_valid, 1'b0);
        chk("arst_after_in_ready", bus.in_ready, 1'b1);
        tick();

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
